// File: rtl/dbg_entry_pkg.sv
// rtl/dbg_entry_pkg.sv - shared constants and types for the debug entry panel
// Purpose: FSM state encoding, digit geometry, button indices and a digit-count helper.
// Ports: none (package dbg_pkg).
package dbg_pkg;

  localparam int DIGITS   = 8;
  localparam int NIBBLE_W = 4;
  localparam int ENTRY_W  = DIGITS * NIBBLE_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ENTRY  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam int BTN_STEP   = 0;
  localparam int BTN_LOAD   = 1;
  localparam int BTN_COMMIT = 2;
  localparam int BTN_CLEAR  = 3;
  localparam int NUM_BTN    = 4;

  typedef struct packed {
    logic clear;
    logic commit;
    logic load;
  } entry_ev_t;

  // Loaded-digit count saturates once the entry register is full.
  function automatic logic [3:0] cnt_inc_sat(input logic [3:0] c);
    return (c >= 4'(DIGITS)) ? 4'(DIGITS) : c + 4'd1;
  endfunction

endpackage

// File: rtl/dbg_entry_if.sv
// rtl/dbg_entry_if.sv - valid/ready commit channel from the entry panel to its sink
// Purpose: bundles the committed-value handshake.
// Ports: commit_valid (entry offered), commit_data (value), commit_ready (sink accepts).
interface dbg_entry_if;
  import dbg_pkg::*;

  logic               commit_valid;
  logic [ENTRY_W-1:0] commit_data;
  logic               commit_ready;

  modport master (output commit_valid, output commit_data, input commit_ready);
  modport slave  (input commit_valid, input commit_data, output commit_ready);
endinterface

// File: rtl/dbg_entry_btn_debounce.sv
// rtl/dbg_entry_btn_debounce.sv - 2-flop synchronizer, debouncer and press pulse for one button
// Purpose: the debounced level follows the synchronized input only after it has differed
//   for DEB_CYCLES consecutive cycles; press is a one-cycle pulse on each 0->1 level change.
// Ports: clk, rst (sync active-high), raw (async button), level (debounced), press (pulse).
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        // DEB_CYCLES-th consecutive differing sample: accept the new level.
        level <= sync2;
        press <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/dbg_entry.sv
// rtl/dbg_entry.sv - front-panel debug entry: single-step, free-run and hex value entry
// Purpose: debounced buttons drive a pipeline step strobe and an IDLE/ENTRY/COMMIT FSM that
//   assembles up to 8 hex digits and offers the value on a valid/ready commit channel.
// Ports: clk, rst (sync active-high); btn_step/btn_load/btn_commit/btn_clear (raw buttons);
//   sw_nibble (digit), sw_run (free-run level); step_pulse, run_en, entry, digit_cnt (status);
//   commit (dbg_entry_if.master: commit_valid, commit_data, commit_ready).
// Option: DBG_ENTRY_AUTOREPEAT_EN adds auto-repeat of a held step button every REPEAT_CYCLES.
module dbg_entry
  import dbg_pkg::*;
#(
  parameter int DEB_CYCLES    = 16,
  parameter int REPEAT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_step,
  input  logic                btn_load,
  input  logic                btn_commit,
  input  logic                btn_clear,
  input  logic [NIBBLE_W-1:0] sw_nibble,
  input  logic                sw_run,
  output logic                step_pulse,
  output logic                run_en,
  output logic [ENTRY_W-1:0]  entry,
  output logic [3:0]          digit_cnt,
  dbg_entry_if.master         commit
);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] lvl;
  logic [NUM_BTN-1:0] press;

  assign raw = {btn_clear, btn_commit, btn_load, btn_step};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw[i]),
      .level (lvl[i]),
      .press (press[i])
    );
  end

  // sw_run is a level switch, so synchronizing is enough.
  logic run_s1;
  always_ff @(posedge clk) begin
    if (rst) begin
      run_s1 <= 1'b0;
      run_en <= 1'b0;
    end else begin
      run_s1 <= sw_run;
      run_en <= run_s1;
    end
  end

  logic unused_levels;

`ifdef DBG_ENTRY_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  logic [RW-1:0] rep_cnt;
  logic          rep_fire;

  // Counts cycles since the last step pulse while the step button stays held in step mode.
  assign rep_fire = lvl[BTN_STEP] && !run_en && !press[BTN_STEP] &&
                    (rep_cnt == RW'(REPEAT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt <= '0;
    end else if (!lvl[BTN_STEP] || run_en || press[BTN_STEP] || rep_fire) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + RW'(1);
    end
  end

  assign step_pulse    = !run_en && (press[BTN_STEP] || rep_fire);
  assign unused_levels = &{1'b0, lvl[NUM_BTN-1:1]};
`else
  assign step_pulse    = press[BTN_STEP] && !run_en;
  // Debounced levels and the repeat period have no consumer in this build.
  assign unused_levels = &{1'b0, lvl, REPEAT_CYCLES[0]};
`endif

  entry_ev_t          ev;
  logic [1:0]         state;
  logic               valid_q;
  logic [ENTRY_W-1:0] data_q;

  assign ev = '{clear: press[BTN_CLEAR], commit: press[BTN_COMMIT], load: press[BTN_LOAD]};

  assign commit.commit_valid = valid_q;
  assign commit.commit_data  = data_q;

  // entry is always zero in IDLE, so a shift-in load covers both the first and later digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      entry     <= '0;
      digit_cnt <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_ENTRY: begin
          if (ev.clear) begin
            entry     <= '0;
            digit_cnt <= '0;
            state     <= ST_IDLE;
          end else if (ev.commit && state == ST_ENTRY) begin
            data_q  <= entry;
            valid_q <= 1'b1;
            state   <= ST_COMMIT;
          end else if (ev.load) begin
            entry     <= {entry[ENTRY_W-NIBBLE_W-1:0], sw_nibble};
            digit_cnt <= cnt_inc_sat(digit_cnt);
            state     <= ST_ENTRY;
          end
        end
        ST_COMMIT: begin
          if (commit.commit_ready) begin
            valid_q   <= 1'b0;
            entry     <= '0;
            digit_cnt <= '0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_entry.sv
// tb/tb_dbg_entry.sv - self-checking bench for dbg_entry
module tb_dbg_entry;
  import dbg_pkg::*;

  localparam int DEB    = 4;
  localparam int REP    = 8;
  localparam int LAT    = 2 + DEB;
  localparam int SETTLE = LAT + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = '0;
  logic [3:0] sw_nibble = '0;
  logic       sw_run = 1'b0;
  logic       step_pulse;
  logic       run_en;
  logic [31:0] entry;
  logic [3:0]  digit_cnt;

  dbg_entry_if bus ();

  always #5 clk = ~clk;

  dbg_entry #(.DEB_CYCLES(DEB), .REPEAT_CYCLES(REP)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_step   (btn[0]),
    .btn_load   (btn[1]),
    .btn_commit (btn[2]),
    .btn_clear  (btn[3]),
    .sw_nibble  (sw_nibble),
    .sw_run     (sw_run),
    .step_pulse (step_pulse),
    .run_en     (run_en),
    .entry      (entry),
    .digit_cnt  (digit_cnt),
    .commit     (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int pulse_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (step_pulse) pulse_q.push_back(cyc);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int b);
    @(negedge clk);
    btn[b] = 1'b1;
    wait_n(SETTLE);
    btn[b] = 1'b0;
    wait_n(SETTLE);
  endtask

  task automatic accept();
    @(negedge clk);
    bus.commit_ready = 1'b1;
    @(negedge clk);
    bus.commit_ready = 1'b0;
  endtask

  typedef enum logic [1:0] {OP_LOAD, OP_CLEAR, OP_COMMIT, OP_ACCEPT} op_e;

  task automatic apply_op(input op_e op, input logic [3:0] nib);
    case (op)
      OP_LOAD:   begin sw_nibble = nib; press(1); end
      OP_CLEAR:  press(3);
      OP_COMMIT: press(2);
      default:   accept();
    endcase
  endtask

  typedef struct {
    op_e         op;
    logic [3:0]  nib;
    logic [31:0] e_entry;
    logic [3:0]  e_cnt;
    logic        e_valid;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: the entry is just the last (up to) 8 digits loaded.
  logic [3:0]  m_digits[$];
  logic        m_pending;
  logic [31:0] m_data;

  function automatic logic [31:0] m_entry();
    logic [31:0] e = '0;
    foreach (m_digits[i]) e = (e << 4) | 32'(m_digits[i]);
    return e;
  endfunction

  task automatic check_state(input string tag, input logic [31:0] e, input logic [3:0] c,
                             input logic v, input logic [31:0] d);
    check({tag, ".entry"}, entry, e);
    check({tag, ".digit_cnt"}, 32'(digit_cnt), 32'(c));
    check({tag, ".valid"}, 32'(bus.commit_valid), 32'(v));
    check({tag, ".data"}, bus.commit_data, d);
  endtask

  initial begin
    int t0;
    int first;
    int in_win;
    int exp_win;
    bus.commit_ready = 1'b0;

    tbl.push_back('{OP_LOAD,    4'h1, 32'h1,        4'd1, 1'b0, 32'h0});
    tbl.push_back('{OP_LOAD,    4'h2, 32'h12,       4'd2, 1'b0, 32'h0});
    tbl.push_back('{OP_LOAD,    4'h3, 32'h123,      4'd3, 1'b0, 32'h0});
    tbl.push_back('{OP_LOAD,    4'h4, 32'h1234,     4'd4, 1'b0, 32'h0});
    tbl.push_back('{OP_LOAD,    4'h5, 32'h12345,    4'd5, 1'b0, 32'h0});
    tbl.push_back('{OP_LOAD,    4'h6, 32'h123456,   4'd6, 1'b0, 32'h0});
    tbl.push_back('{OP_LOAD,    4'h7, 32'h1234567,  4'd7, 1'b0, 32'h0});
    tbl.push_back('{OP_LOAD,    4'h8, 32'h12345678, 4'd8, 1'b0, 32'h0});
    tbl.push_back('{OP_LOAD,    4'h9, 32'h23456789, 4'd8, 1'b0, 32'h0});
    tbl.push_back('{OP_COMMIT,  4'h0, 32'h23456789, 4'd8, 1'b1, 32'h23456789});
    tbl.push_back('{OP_LOAD,    4'h7, 32'h23456789, 4'd8, 1'b1, 32'h23456789});
    tbl.push_back('{OP_CLEAR,   4'h0, 32'h23456789, 4'd8, 1'b1, 32'h23456789});
    tbl.push_back('{OP_ACCEPT,  4'h0, 32'h0,        4'd0, 1'b0, 32'h23456789});
    tbl.push_back('{OP_COMMIT,  4'h0, 32'h0,        4'd0, 1'b0, 32'h23456789});
    tbl.push_back('{OP_ACCEPT,  4'h0, 32'h0,        4'd0, 1'b0, 32'h23456789});
    tbl.push_back('{OP_LOAD,    4'hF, 32'hF,        4'd1, 1'b0, 32'h23456789});
    tbl.push_back('{OP_CLEAR,   4'h0, 32'h0,        4'd0, 1'b0, 32'h23456789});
    tbl.push_back('{OP_LOAD,    4'h5, 32'h5,        4'd1, 1'b0, 32'h23456789});
    tbl.push_back('{OP_COMMIT,  4'h0, 32'h5,        4'd1, 1'b1, 32'h5});
    tbl.push_back('{OP_ACCEPT,  4'h0, 32'h0,        4'd0, 1'b0, 32'h5});

    // Reset state
    sw_run = 1'b1;
    wait_n(5);
    check_state("reset", 32'h0, 4'd0, 1'b0, 32'h0);
    check("reset.step_pulse", 32'(step_pulse), 32'h0);
    check("reset.run_en", 32'(run_en), 32'h0);
    sw_run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_n(3);

    foreach (tbl[i])
      begin
        apply_op(tbl[i].op, tbl[i].nib);
        check_state($sformatf("tbl%0d", i), tbl[i].e_entry, tbl[i].e_cnt, tbl[i].e_valid,
                    tbl[i].e_data);
      end

    // Short glitch on load is filtered
    apply_op(OP_LOAD, 4'h3);
    @(negedge clk);
    btn[1] = 1'b1;
    wait_n(DEB - 1);
    btn[1] = 1'b0;
    wait_n(SETTLE + 2);
    check("glitch.entry", entry, 32'h3);
    check("glitch.cnt", 32'(digit_cnt), 32'd1);

    // Clear and commit land in the same cycle: clear wins
    @(negedge clk);
    btn[3] = 1'b1;
    btn[2] = 1'b1;
    wait_n(SETTLE);
    btn = '0;
    wait_n(SETTLE);
    check("clr_commit.entry", entry, 32'h0);
    check("clr_commit.valid", 32'(bus.commit_valid), 32'h0);

    // Commit held stable while the sink stalls
    apply_op(OP_LOAD, 4'hA);
    apply_op(OP_LOAD, 4'hB);
    apply_op(OP_COMMIT, 4'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d.valid", k), 32'(bus.commit_valid), 32'h1);
      check($sformatf("hold%0d.data", k), bus.commit_data, 32'hAB);
    end
    bus.commit_ready = 1'b1;
    @(negedge clk);
    bus.commit_ready = 1'b0;
    check("xfer.valid", 32'(bus.commit_valid), 32'h0);
    check("xfer.entry", entry, 32'h0);
    check("xfer.cnt", 32'(digit_cnt), 32'h0);

    // Reset aborts a pending commit
    apply_op(OP_LOAD, 4'hC);
    apply_op(OP_COMMIT, 4'h0);
    check("pre_rst.valid", 32'(bus.commit_valid), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_state("rst_commit", 32'h0, 4'd0, 1'b0, 32'h0);

    // Step latency and (auto-)repeat behaviour
    wait_n(3);
    pulse_q.delete();
    @(negedge clk);
    t0 = cyc;
    btn[0] = 1'b1;
    wait_n(LAT + 30);
    btn[0] = 1'b0;
    wait_n(SETTLE + 4);
    check("step.any_pulse", 32'(pulse_q.size() > 0), 32'h1);
    if (pulse_q.size() > 0) begin
      first = pulse_q[0];
      check("step.latency", 32'(first - t0), 32'(LAT));
      in_win = 0;
      foreach (pulse_q[i]) if (pulse_q[i] <= first + 30) in_win++;
`ifdef DBG_ENTRY_AUTOREPEAT_EN
      exp_win = 4;
      for (int k = 1; k < 4 && k < pulse_q.size(); k++)
        check($sformatf("repeat%0d.spacing", k), 32'(pulse_q[k] - pulse_q[k-1]), 32'(REP));
`else
      exp_win = 1;
      check("step.total", 32'(pulse_q.size()), 32'd1);
`endif
      check("step.window_count", 32'(in_win), 32'(exp_win));
    end

    // Step is discarded in free-run mode
    sw_run = 1'b1;
    wait_n(3);
    check("run.run_en", 32'(run_en), 32'h1);
    pulse_q.delete();
    press(0);
    check("run.no_step", 32'(pulse_q.size()), 32'h0);
    sw_run = 1'b0;
    wait_n(3);
    check("run.off", 32'(run_en), 32'h0);

    // Button held through reset deassertion acts as a fresh press
    sw_nibble = 4'h6;
    @(negedge clk);
    btn[1] = 1'b1;
    rst = 1'b1;
    wait_n(3);
    rst = 1'b0;
    wait_n(LAT + 1);
    check("held_rst.entry", entry, 32'h6);
    check("held_rst.cnt", 32'(digit_cnt), 32'd1);
    btn[1] = 1'b0;
    wait_n(SETTLE);
    apply_op(OP_CLEAR, 4'h0);

    // Randomized operations against the digit-queue model
    m_digits.delete();
    m_pending = 1'b0;
    m_data = 32'h0;
    for (int n = 0; n < 40; n++) begin
      int r;
      op_e op;
      logic [3:0] nib;
      r = $urandom_range(0, 9);
      nib = 4'($urandom_range(0, 15));
      op = (r < 5) ? OP_LOAD : (r == 5) ? OP_CLEAR : (r < 8) ? OP_COMMIT : OP_ACCEPT;
      apply_op(op, nib);
      case (op)
        OP_LOAD: if (!m_pending) begin
          m_digits.push_back(nib);
          if (m_digits.size() > DIGITS) void'(m_digits.pop_front());
        end
        OP_CLEAR: if (!m_pending) m_digits.delete();
        OP_COMMIT: if (!m_pending && m_digits.size() > 0) begin
          m_pending = 1'b1;
          m_data = m_entry();
        end
        default: if (m_pending) begin
          m_pending = 1'b0;
          m_digits.delete();
        end
      endcase
      check_state($sformatf("rnd%0d", n), m_entry(), 4'(m_digits.size()), m_pending, m_data);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dbg_entry.md
DBG_ENTRY -- requirements
Module: dbg_entry

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16: consecutive stable cycles required before a debounced button level changes.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 64: auto-repeat period for a held step button (used only under REQ-024).
REQ-003 SHALL use one clock and a synchronous, active-high reset; ports: clk  in  1  system clock; rst  in  1  reset.
REQ-004 SHALL have ports: btn_step  in  1  raw single-step button; btn_load  in  1  raw digit-load button; btn_commit  in  1  raw commit button; btn_clear  in  1  raw entry-clear button.
REQ-005 SHALL have ports: sw_nibble  in  4  hex digit to load; sw_run  in  1  free-run request level.
REQ-006 SHALL have ports: step_pulse  out  1  one-cycle pipeline step strobe; run_en  out  1  free-run enable; entry  out  32  value being entered, for display; digit_cnt  out  4  digits loaded, 0..8.
REQ-007 SHALL have ports: commit_valid  out  1  entry offered to sink; commit_data  out  32  committed value; commit_ready  in  1  sink accepts.

Function
REQ-008 Each raw button input SHALL pass through a 2-flop synchronizer, then a debouncer; debounced level changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles.
REQ-009 A press event SHALL be a one-cycle pulse in the cycle the debounced level goes 0->1; releases produce no event.
REQ-010 Latency from a clean raw 0->1 transition to the press event SHALL be exactly 2+DEB_CYCLES cycles; a glitch shorter than DEB_CYCLES cycles SHALL produce no event.
REQ-011 sw_run SHALL be synchronized only (2 flops, not debounced); run_en SHALL equal the synchronized value.
REQ-012 step_pulse SHALL be a one-cycle pulse per step press event, and only while run_en=0; step presses while run_en=1 are discarded.
REQ-013 The FSM SHALL have states IDLE, ENTRY, COMMIT.
REQ-014 IDLE, load event: entry <= {28'b0, sw_nibble}, digit_cnt <= 1, go to ENTRY.
REQ-015 ENTRY, load event: entry <= {entry[27:0], sw_nibble}, digit_cnt saturates at 8; a ninth or later digit shifts the oldest digit out.
REQ-016 IDLE or ENTRY, clear event: entry <= 0, digit_cnt <= 0, go to IDLE.
REQ-017 ENTRY, commit event: commit_data <= entry, commit_valid <= 1, go to COMMIT; a commit event in IDLE is ignored.
REQ-018 COMMIT: commit_valid and commit_data SHALL hold stable until a cycle with commit_ready=1; in that cycle the transfer completes, and in the next cycle commit_valid=0, entry=0, digit_cnt=0, state IDLE.
REQ-019 In COMMIT, load, clear and commit events SHALL be discarded; step handling is unaffected.
REQ-020 Simultaneous events in IDLE/ENTRY: priority SHALL be clear > commit > load; lower-priority events in that cycle are discarded.
REQ-021 commit_ready while commit_valid=0 SHALL have no effect.

Reset
REQ-022 On rst=1 at a clock edge: state IDLE, entry=0, digit_cnt=0, commit_valid=0, commit_data=0, step_pulse=0, run_en=0, and all synchronizer, debounce and repeat counters and levels 0; this also aborts an in-progress COMMIT, with no transfer.
REQ-023 A button held through reset deassertion SHALL produce a press event after DEB_CYCLES stable cycles, as for a fresh press.

Configuration
REQ-024 With DBG_ENTRY_AUTOREPEAT_EN defined: while the debounced step level stays 1 and run_en=0, a further step_pulse SHALL occur every REPEAT_CYCLES cycles after the initial press pulse; the count restarts on release or on run_en=1.
REQ-025 Without DBG_ENTRY_AUTOREPEAT_EN: exactly one step_pulse per press; REPEAT_CYCLES is unused and no repeat counter exists.

Structure
REQ-026 Package dbg_pkg SHALL hold the FSM state encoding (IDLE=2'd0, ENTRY=2'd1, COMMIT=2'd2), DIGITS=8 and the nibble width 4.
REQ-027 Sub-module btn_debounce (synchronizer, debouncer and press-pulse output) SHALL be instantiated once per button.

Verification (DEB_CYCLES=4, REPEAT_CYCLES=8)
REQ-028 btn_load high for 3 cycles, then low -> no event, entry unchanged.
REQ-029 Load nibbles 1,2,...,9 (sw_nibble set before each press) -> entry=0x23456789, digit_cnt=8.
REQ-030 Enter 0xAB, commit, commit_ready=0 for 5 cycles -> commit_valid=1, commit_data=0xAB held stable; ready=1 -> next cycle valid=0, entry=0, state IDLE.
REQ-031 Clear and commit events in the same cycle in ENTRY -> entry=0, no commit_valid.
REQ-032 sw_run=1, press step -> no step_pulse; with AUTOREPEAT_EN defined, sw_run=0 and step held 30 cycles after the first pulse -> 1+3 pulses, spaced 8 cycles.
REQ-033 rst asserted in COMMIT -> next cycle commit_valid=0, entry=0, digit_cnt=0.
